// File: rtl/nbit1by2demux_reg.sv
// nbit1by2demux_reg: routes one input word to one of two 2-entry
// registered FIFO lanes, with pass-through on full and sync flush.

// One output lane: 2-entry FIFO kept as head/tail registers plus state.
module nbit1by2demux_reg_lane #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic         valid,
    output logic [N-1:0] data,
    output logic [1:0]   count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] head;
    logic [N-1:0] head_nx;
    logic [N-1:0] tail;
    logic [N-1:0] tail_nx;

    // lane registers; reset clears data too so nothing stale can leak
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nx;
            head  <= head_nx;
            tail  <= tail_nx;
        end
    end

    // next-state and data movement; flush wins over push and pop
    always_comb begin
        state_nx = state;
        head_nx  = head;
        tail_nx  = tail;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state_nx = ONE;
                        head_nx  = din;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        push && pop: begin
                            head_nx = din;
                        end
                        push && !pop: begin
                            state_nx = FULL;
                            tail_nx  = din;
                        end
                        !push && pop: begin
                            state_nx = EMPTY;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head_nx = tail;
                        if (push) begin
                            tail_nx = din;
                        end else begin
                            state_nx = ONE;
                        end
                    end
                end
                default: begin
                    state_nx = EMPTY;
                end
            endcase
        end
    end

    assign valid = (state != EMPTY);
    assign data  = head;
    assign count = state;

endmodule

// Top: steer the accepted word to the lane picked by sel.
module nbit1by2demux_reg #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         sel,
    output logic         in_ready,
    input  logic         flush,
    output logic         out0_valid,
    output logic [N-1:0] out0_data,
    input  logic         out0_ready,
    output logic [1:0]   out0_count,
    output logic         out1_valid,
    output logic [N-1:0] out1_data,
    input  logic         out1_ready,
    output logic [1:0]   out1_count
);

    logic acc;
    logic rdy0;
    logic rdy1;
    logic pop0;
    logic pop1;

    // a full lane still takes a word when its sink drains the head
    assign rdy0 = (out0_count < 2'(DEPTH)) | out0_ready;
    assign rdy1 = (out1_count < 2'(DEPTH)) | out1_ready;

    assign in_ready = !rst && !flush && (sel ? rdy1 : rdy0);
    assign acc      = in_valid && in_ready;
    assign pop0     = out0_valid && out0_ready;
    assign pop1     = out1_valid && out1_ready;

    nbit1by2demux_reg_lane #(.N(N)) u_lane0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (acc && !sel),
        .pop   (pop0),
        .din   (in_data),
        .valid (out0_valid),
        .data  (out0_data),
        .count (out0_count)
    );

    nbit1by2demux_reg_lane #(.N(N)) u_lane1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (acc && sel),
        .pop   (pop1),
        .din   (in_data),
        .valid (out1_valid),
        .data  (out1_data),
        .count (out1_count)
    );

endmodule

// File: tb/tb_nbit1by2demux_reg.sv
// tb_nbit1by2demux_reg: directed vectors, per-lane expected-word
// queues filled by the driver and drained by a separate monitor.
module tb_nbit1by2demux_reg;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         sel;
    logic         in_ready;
    logic         flush;
    logic         out0_valid;
    logic [N-1:0] out0_data;
    logic         out0_ready;
    logic [1:0]   out0_count;
    logic         out1_valid;
    logic [N-1:0] out1_data;
    logic         out1_ready;
    logic [1:0]   out1_count;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] q0[$];
    logic [N-1:0] q1[$];

    nbit1by2demux_reg #(.N(N), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .sel        (sel),
        .in_ready   (in_ready),
        .flush      (flush),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out0_count (out0_count),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // drive at negedge, sample 1ns before the next rising edge
    task automatic step(input logic v, input logic s,
                        input logic [N-1:0] d, input logic r0,
                        input logic r1, input logic f, input logic er);
        @(negedge clk);
        in_valid   = v;
        sel        = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        flush      = f;
        #4;
        chk("in_ready", {31'b0, in_ready}, {31'b0, er});
        if (f) begin
            q0.delete();
            q1.delete();
        end else if (v && er) begin
            if (s) q1.push_back(d);
            else q0.push_back(d);
        end
    endtask

    task automatic st(input logic [1:0] c0, input logic [1:0] c1);
        chk("count0", {30'b0, out0_count}, {30'b0, c0});
        chk("count1", {30'b0, out1_count}, {30'b0, c1});
        chk("valid0", {31'b0, out0_valid}, {31'b0, (c0 != 2'd0)});
        chk("valid1", {31'b0, out1_valid}, {31'b0, (c1 != 2'd0)});
    endtask

    // monitor: every pop must match the oldest expected word of that lane
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out0_valid && out0_ready) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop0: got %h want none", out0_data);
                end else begin
                    chk("pop0", out0_data, q0.pop_front());
                end
            end
            if (!rst && out1_valid && out1_ready) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop1: got %h want none", out1_data);
                end else begin
                    chk("pop1", out1_data, q1.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'h5;
        sel        = 1'b0;
        flush      = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #3;
        st(2'd0, 2'd0);
        chk("rst_rdy", {31'b0, in_ready}, 32'd0);
        chk("rst_d0", out0_data, 32'd0);
        chk("rst_d1", out1_data, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // route and latency
        step(1, 0, 32'hAAAA0001, 0, 0, 0, 1); st(0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 1);        st(1, 0);
        chk("lat_d0", out0_data, 32'hAAAA0001);
        step(0, 0, 32'h0, 1, 0, 0, 1);        st(1, 0);
        step(0, 0, 32'h0, 0, 0, 0, 1);        st(0, 0);

        // fill and backpressure on lane 1
        step(1, 1, 32'h11, 0, 0, 0, 1); st(0, 0);
        step(1, 1, 32'h22, 0, 0, 0, 1); st(0, 1);
        step(1, 1, 32'h33, 0, 0, 0, 0); st(0, 2);
        step(0, 0, 32'h0, 0, 0, 0, 1);  st(0, 2);
        step(0, 1, 32'h0, 0, 0, 0, 0);  st(0, 2);
        step(1, 1, 32'h33, 0, 1, 0, 1); st(0, 2);
        step(0, 1, 32'h0, 0, 1, 0, 1);  st(0, 2);
        step(0, 1, 32'h0, 0, 1, 0, 1);  st(0, 1);
        step(0, 0, 32'h0, 0, 0, 0, 1);  st(0, 0);

        // full pass-through on lane 0
        step(1, 0, 32'h1, 0, 0, 0, 1); st(0, 0);
        step(1, 0, 32'h2, 0, 0, 0, 1); st(1, 0);
        step(1, 0, 32'h3, 1, 0, 0, 1); st(2, 0);
        chk("pt_d0a", out0_data, 32'h1);
        step(0, 0, 32'h0, 0, 0, 0, 0); st(2, 0);
        chk("pt_d0b", out0_data, 32'h2);
        step(0, 0, 32'h0, 1, 0, 0, 1); st(2, 0);
        step(0, 0, 32'h0, 1, 0, 0, 1); st(1, 0);
        chk("pt_d0c", out0_data, 32'h3);
        step(0, 0, 32'h0, 0, 0, 0, 1); st(0, 0);

        // concurrent pops on both lanes plus an accept
        step(1, 0, 32'hA0, 0, 0, 0, 1); st(0, 0);
        step(1, 1, 32'hB0, 0, 0, 0, 1); st(1, 0);
        step(1, 1, 32'hB1, 1, 1, 0, 1); st(1, 1);
        step(0, 0, 32'h0, 0, 0, 0, 1);  st(0, 1);
        chk("cc_d1", out1_data, 32'hB1);

        // flush beats a simultaneous accept
        step(1, 0, 32'hC0, 0, 0, 0, 1); st(0, 1);
        step(1, 0, 32'hC1, 0, 0, 0, 1); st(1, 1);
        step(1, 0, 32'hC2, 0, 0, 1, 0); st(2, 1);
        step(0, 0, 32'h0, 0, 0, 0, 1);  st(0, 0);
        step(0, 0, 32'h0, 1, 1, 0, 1);  st(0, 0);

        // async reset with both lanes full
        step(1, 0, 32'hD0, 0, 0, 0, 1); st(0, 0);
        step(1, 0, 32'hD1, 0, 0, 0, 1); st(1, 0);
        step(1, 1, 32'hE0, 0, 0, 0, 1); st(2, 0);
        step(1, 1, 32'hE1, 0, 0, 0, 1); st(2, 1);
        step(0, 0, 32'h0, 0, 0, 0, 0);  st(2, 2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        st(2'd0, 2'd0);
        chk("ar_rdy", {31'b0, in_ready}, 32'd0);
        chk("ar_d0", out0_data, 32'd0);
        chk("ar_d1", out1_data, 32'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 32'h0, 1, 1, 0, 1);  st(0, 0);
        step(0, 1, 32'h0, 1, 1, 0, 1);  st(0, 0);
        step(1, 1, 32'hF0, 0, 1, 0, 1); st(0, 0);
        step(0, 1, 32'h0, 0, 1, 0, 1);  st(0, 1);
        chk("ar_f0", out1_data, 32'hF0);
        step(0, 0, 32'h0, 0, 0, 0, 1);  st(0, 0);

        chk("q0_left", q0.size(), 32'd0);
        chk("q1_left", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nbit1by2demux_reg.md
NBIT1BY2DEMUX_REG -- requirements
Module: nbit1by2demux_reg

Interface
REQ-001 Parameter N, default 32, data word width in bits.
REQ-002 Parameter DEPTH, fixed at 2, entries per output lane; other values are unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  source presents a word.
REQ-006 in_data  input  N  source word.
REQ-007 sel  input  1  destination lane for the presented word: 0 = lane 0, 1 = lane 1.
REQ-008 in_ready  output  1  block accepts the presented word this cycle.
REQ-009 flush  input  1  synchronous discard of all buffered words.
REQ-010 out0_valid, out1_valid  output  1 each  lane holds a word.
REQ-011 out0_data, out1_data  output  N each  oldest word of the lane.
REQ-012 out0_ready, out1_ready  input  1 each  sink consumes the lane word this cycle.
REQ-013 out0_count, out1_count  output  2 each  entries held per lane, 0..2.

Function
REQ-014 Each lane SHALL be an independent 2-entry FIFO: head register, tail register, count.
- Per-lane states:
  - EMPTY (count 0)
  - ONE (count 1)
  - FULL (count 2)
REQ-015 Accept: a word SHALL be accepted when in_valid=1 and in_ready=1.
- The word is routed only to the lane chosen by sel.
- The other lane is untouched.
REQ-016 Pop: a lane SHALL pop when outX_valid=1 and outX_ready=1.
REQ-017 in_ready SHALL be combinational and equal to: selected lane count<2, OR selected lane count==2 AND its outX_ready=1 (pass-through on full).
REQ-018 in_ready SHALL be 0 while flush=1 or rst=1.
REQ-019 outX_valid SHALL equal (countX!=0) and SHALL depend only on registered state.
REQ-020 outX_data SHALL always drive the lane head register.
REQ-021 Latency: an accepted word SHALL appear on its lane outputs the cycle after the accepting edge; there is no combinational in-to-out path.
REQ-022 Ordering: each lane SHALL deliver words in acceptance order. No ordering is guaranteed between lanes.
REQ-023 Transitions per lane (accept means an accept targeting this lane):
- EMPTY + accept -> ONE, head=in_data.
- ONE + accept, no pop -> FULL, tail=in_data.
- ONE + pop, no accept -> EMPTY.
- ONE + accept + pop -> ONE, head=in_data.
- FULL + pop, no accept -> ONE, head=tail.
- FULL + accept + pop -> FULL, head=tail, tail=in_data.
- No event -> state and registers held.
REQ-024 A pop on an EMPTY lane SHALL have no effect.
REQ-025 An accept while in_ready=0 SHALL have no effect, and the source must hold in_data/sel.
REQ-026 Simultaneous pops on both lanes plus an accept SHALL all complete in the same cycle.
REQ-027 flush=1 at an edge SHALL set both counts to 0.
- Flush overrides any simultaneous accept or pop.
- Data registers need not clear.
REQ-028 outX_count SHALL reflect registered count, updated on the same edge as the state.
REQ-029 sel SHALL be ignored when in_valid=0.

Reset
REQ-030 On rst assertion, all lane state SHALL be forced immediately, without waiting for clk:
- out0_valid=out1_valid=0
- out0_count=out1_count=0
- out0_data=out1_data=0
- internal tail registers=0
REQ-031 in_ready SHALL be 0 while rst=1 and SHALL follow REQ-017 from the first edge after rst deasserts.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered words. No word accepted before reset SHALL appear afterwards.

Verification
REQ-033 Route and latency: rst released, in_valid=1, sel=0, in_data=0xAAAA0001 for one cycle, out0_ready=0 -> next cycle out0_valid=1, out0_data=0xAAAA0001, out0_count=1; out1_valid=0.
REQ-034 Fill and backpressure: lane 1, sinks stalled, send 0x11, 0x22, 0x33 -> first two accepted, out1_count=2, in_ready=0 with sel=1 while in_ready=1 with sel=0; assert out1_ready -> pops 0x11, 0x22, then 0x33 in order.
REQ-035 Full pass-through: lane 0 FULL holding 0x1, 0x2, out0_ready=1, accept 0x3 on the same edge -> out0_count stays 2, out0_data=0x2, then 0x3.
REQ-036 Concurrent: both lanes ONE, both ready=1, accept to lane 1 on the same edge -> lane 0 EMPTY, lane 1 ONE holding the new word.
REQ-037 Flush priority: lanes hold 2 and 1 words, flush=1 with in_valid=1 -> both counts 0 next cycle, new word dropped, in_ready=0 during flush.
REQ-038 Async reset: assert rst between clock edges with both lanes FULL -> valid and count outputs go to 0 before the next edge; after release no stale word appears.
